// File: rtl/mem_port_arbiter_pkg.sv
// Shared types for the imem/dmem memory-port arbiter.
package rv32i_types;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT} arb_state_t;

  // Requester ids, used for the winner / last-served flags.
  localparam logic SEL_IMEM = 1'b0;
  localparam logic SEL_DMEM = 1'b1;

  // One memory request at the default 32-bit address/data widths.
  typedef struct packed {
    logic [31:0] addr;
    logic [3:0]  rmask;
    logic [3:0]  wmask;
    logic [31:0] wdata;
  } mem_req_t;

endpackage

// File: rtl/mem_port_arbiter_buf.sv
// One pending-request buffer: captures a request pulse and holds it until cleared.
module mem_req_buf
  import rv32i_types::*;
#(
  parameter type req_t = mem_req_t
) (
  input  logic clk,
  input  logic rst_n,
  input  logic capture,
  input  req_t req_in,
  input  logic clear,
  output logic valid,
  output req_t req
);

  // Capture wins over a coincident clear so a requester can re-request in its resp cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid <= 1'b0;
      req   <= '0;
    end else if (capture && (!valid || clear)) begin
      valid <= 1'b1;
      req   <= req_in;
    end else if (clear) begin
      valid <= 1'b0;
    end
  end

  // A new request while this buffer still holds one is dropped; flag it.
  always @(posedge clk) begin
    if (rst_n) assert (!(capture && valid && !clear));
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one memory port between instruction fetch and data access.
module mem_port_arbiter
  import rv32i_types::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [ADDR_W-1:0]   imem_addr,
  input  logic [DATA_W/8-1:0] imem_rmask,
  output logic [DATA_W-1:0]   imem_rdata,
  output logic                imem_resp,
  input  logic [ADDR_W-1:0]   dmem_addr,
  input  logic [DATA_W/8-1:0] dmem_rmask,
  input  logic [DATA_W/8-1:0] dmem_wmask,
  input  logic [DATA_W-1:0]   dmem_wdata,
  output logic [DATA_W-1:0]   dmem_rdata,
  output logic                dmem_resp,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W/8-1:0] mem_rmask,
  output logic [DATA_W/8-1:0] mem_wmask,
  output logic [DATA_W-1:0]   mem_wdata,
  input  logic [DATA_W-1:0]   mem_rdata,
  input  logic                mem_resp
);

  localparam int MW = DATA_W / 8;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [MW-1:0]     rmask;
    logic [MW-1:0]     wmask;
    logic [DATA_W-1:0] wdata;
  } req_t;

  arb_state_t state;
  logic       winner, last_served;
  logic       i_valid, d_valid, i_cap, d_cap, i_clr, d_clr;
  logic       resp_ok, pick_d;
  req_t       i_in, d_in, i_buf, d_buf, win_buf;

  assign i_in  = '{addr: imem_addr, rmask: imem_rmask, wmask: '0, wdata: '0};
  assign d_in  = '{addr: dmem_addr, rmask: dmem_rmask, wmask: dmem_wmask, wdata: dmem_wdata};
  assign i_cap = |imem_rmask;
  assign d_cap = (|dmem_rmask) || (|dmem_wmask);

  // A response only counts while a transaction is outstanding.
  assign resp_ok = mem_resp && (state != IDLE);
  assign i_clr   = resp_ok && (winner == SEL_IMEM);
  assign d_clr   = resp_ok && (winner == SEL_DMEM);

  mem_req_buf #(.req_t(req_t)) u_ibuf (
    .clk(clk), .rst_n(rst_n), .capture(i_cap), .req_in(i_in),
    .clear(i_clr), .valid(i_valid), .req(i_buf)
  );

  mem_req_buf #(.req_t(req_t)) u_dbuf (
    .clk(clk), .rst_n(rst_n), .capture(d_cap), .req_in(d_in),
    .clear(d_clr), .valid(d_valid), .req(d_buf)
  );

  // dmem wins when alone or on a tie after imem was served last.
  assign pick_d  = d_valid && (!i_valid || (last_served == SEL_IMEM));
  assign win_buf = pick_d ? d_buf : i_buf;

  // Issue FSM with registered downstream outputs; masks live for the ISSUE cycle only.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      winner      <= SEL_IMEM;
      last_served <= SEL_IMEM;
      mem_addr    <= '0;
      mem_rmask   <= '0;
      mem_wmask   <= '0;
      mem_wdata   <= '0;
    end else begin
      case (state)
        IDLE: if (i_valid || d_valid) begin
          winner      <= pick_d;
          last_served <= pick_d;
          mem_addr    <= win_buf.addr;
          mem_rmask   <= win_buf.rmask;
          mem_wmask   <= win_buf.wmask;
          mem_wdata   <= win_buf.wdata;
          state       <= ISSUE;
        end
        ISSUE: begin
          mem_rmask <= '0;
          mem_wmask <= '0;
          state     <= mem_resp ? IDLE : WAIT;
        end
        WAIT: if (mem_resp) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Route the response back to the owner of the outstanding transaction.
  always_comb begin
    imem_resp  = i_clr;
    dmem_resp  = d_clr;
    imem_rdata = i_clr ? mem_rdata : '0;
    dmem_rdata = d_clr ? mem_rdata : '0;
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed, table-driven bench for mem_port_arbiter.
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] imem_addr, dmem_addr, dmem_wdata, mem_rdata;
  logic [3:0]  imem_rmask, dmem_rmask, dmem_wmask;
  logic        mem_resp;
  logic [31:0] imem_rdata, dmem_rdata, mem_addr, mem_wdata;
  logic        imem_resp, dmem_resp;
  logic [3:0]  mem_rmask, mem_wmask;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .imem_addr(imem_addr), .imem_rmask(imem_rmask),
    .imem_rdata(imem_rdata), .imem_resp(imem_resp),
    .dmem_addr(dmem_addr), .dmem_rmask(dmem_rmask), .dmem_wmask(dmem_wmask),
    .dmem_wdata(dmem_wdata), .dmem_rdata(dmem_rdata), .dmem_resp(dmem_resp),
    .mem_addr(mem_addr), .mem_rmask(mem_rmask), .mem_wmask(mem_wmask),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_resp(mem_resp)
  );

  typedef struct {
    logic        rst;
    logic [3:0]  irm;
    logic [31:0] ia;
    logic [3:0]  drm, dwm;
    logic [31:0] da, dwd;
    logic        mr;
    logic [31:0] mrd;
    logic        ei, ed;
    logic [3:0]  emr, emw;
    logic        aw;
    logic [31:0] ea, ewd;
  } vec_t;

  function automatic vec_t mkv(input logic rst, input logic [3:0] irm, input logic [31:0] ia,
                               input logic [3:0] drm, input logic [3:0] dwm,
                               input logic [31:0] da, input logic [31:0] dwd,
                               input logic mr, input logic [31:0] mrd,
                               input logic ei, input logic ed,
                               input logic [3:0] emr, input logic [3:0] emw,
                               input logic aw, input logic [31:0] ea, input logic [31:0] ewd);
    vec_t v;
    v.rst = rst; v.irm = irm; v.ia = ia; v.drm = drm; v.dwm = dwm; v.da = da; v.dwd = dwd;
    v.mr = mr; v.mrd = mrd; v.ei = ei; v.ed = ed; v.emr = emr; v.emw = emw;
    v.aw = aw; v.ea = ea; v.ewd = ewd;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic idle_inputs();
    imem_rmask = '0; imem_addr = '0;
    dmem_rmask = '0; dmem_wmask = '0; dmem_addr = '0; dmem_wdata = '0;
    mem_resp = 1'b0; mem_rdata = '0;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_imem_resp"}, {31'd0, imem_resp}, 32'd0);
    chk({tag, "_dmem_resp"}, {31'd0, dmem_resp}, 32'd0);
    chk({tag, "_mem_rmask"}, {28'd0, mem_rmask}, 32'd0);
    chk({tag, "_mem_wmask"}, {28'd0, mem_wmask}, 32'd0);
    chk({tag, "_mem_addr"},  mem_addr, 32'd0);
    chk({tag, "_mem_wdata"}, mem_wdata, 32'd0);
  endtask

  vec_t vecs[22];

  initial begin
    // Cycle-by-cycle script; each entry is driven at a falling edge and checked 1 ns later.
    //             rst irm   ia            drm   dwm   da            dwd           mr mrd           ei ed emr   emw   aw ea            ewd
    vecs[0]  = mkv(0, 4'hF, 32'h6000_0000, 4'h0, 4'h0, 32'h0,        32'h0,        0, 32'h0,        0, 0, 4'h0, 4'h0, 0, 32'h0,        32'h0);
    vecs[1]  = mkv(0, 4'h0, 32'h0,        4'h0, 4'h0, 32'h0,        32'h0,        0, 32'h0,        0, 0, 4'h0, 4'h0, 0, 32'h0,        32'h0);
    vecs[2]  = mkv(0, 4'h0, 32'h0,        4'h0, 4'h0, 32'h0,        32'h0,        0, 32'h0,        0, 0, 4'hF, 4'h0, 1, 32'h6000_0000, 32'h0);
    vecs[3]  = mkv(0, 4'h0, 32'h0,        4'h0, 4'h0, 32'h0,        32'h0,        0, 32'h0,        0, 0, 4'h0, 4'h0, 0, 32'h0,        32'h0);
    vecs[4]  = mkv(0, 4'h0, 32'h0,        4'h0, 4'h0, 32'h0,        32'h0,        0, 32'h0,        0, 0, 4'h0, 4'h0, 0, 32'h0,        32'h0);
    vecs[5]  = mkv(0, 4'h0, 32'h0,        4'h0, 4'h0, 32'h0,        32'h0,        1, 32'h0000_0013, 1, 0, 4'h0, 4'h0, 0, 32'h0,        32'h0);
    vecs[6]  = mkv(0, 4'h0, 32'h0,        4'h0, 4'h0, 32'h0,        32'h0,        1, 32'h5555_5555, 0, 0, 4'h0, 4'h0, 0, 32'h0,        32'h0);
    vecs[7]  = mkv(0, 4'h0, 32'h0,        4'h0, 4'h0, 32'h0,        32'h0,        0, 32'h0,        0, 0, 4'h0, 4'h0, 0, 32'h0,        32'h0);
    vecs[8]  = mkv(0, 4'h0, 32'h0,        4'h0, 4'h3, 32'h7000_0010, 32'hDEAD_BEEF, 0, 32'h0,        0, 0, 4'h0, 4'h0, 0, 32'h0,        32'h0);
    vecs[9]  = mkv(0, 4'h0, 32'h0,        4'h0, 4'h0, 32'h0,        32'h0,        0, 32'h0,        0, 0, 4'h0, 4'h0, 0, 32'h0,        32'h0);
    vecs[10] = mkv(0, 4'h0, 32'h0,        4'h0, 4'h0, 32'h0,        32'h0,        1, 32'h0,        0, 1, 4'h0, 4'h3, 1, 32'h7000_0010, 32'hDEAD_BEEF);
    vecs[11] = mkv(0, 4'h0, 32'h0,        4'h0, 4'h0, 32'h0,        32'h0,        0, 32'h0,        0, 0, 4'h0, 4'h0, 0, 32'h0,        32'h0);
    vecs[12] = mkv(0, 4'h0, 32'h0,        4'h0, 4'h0, 32'h0,        32'h0,        0, 32'h0,        0, 0, 4'h0, 4'h0, 0, 32'h0,        32'h0);
    vecs[13] = mkv(1, 4'h0, 32'h0,        4'h0, 4'h0, 32'h0,        32'h0,        0, 32'h0,        0, 0, 4'h0, 4'h0, 1, 32'h0,        32'h0);
    vecs[14] = mkv(0, 4'hF, 32'h6000_0004, 4'hF, 4'h0, 32'h7000_0000, 32'h0,       0, 32'h0,        0, 0, 4'h0, 4'h0, 0, 32'h0,        32'h0);
    vecs[15] = mkv(0, 4'h0, 32'h0,        4'h0, 4'h0, 32'h0,        32'h0,        0, 32'h0,        0, 0, 4'h0, 4'h0, 0, 32'h0,        32'h0);
    vecs[16] = mkv(0, 4'h0, 32'h0,        4'h0, 4'h0, 32'h0,        32'h0,        0, 32'h0,        0, 0, 4'hF, 4'h0, 1, 32'h7000_0000, 32'h0);
    vecs[17] = mkv(0, 4'h0, 32'h0,        4'h0, 4'h0, 32'h0,        32'h0,        0, 32'h0,        0, 0, 4'h0, 4'h0, 0, 32'h0,        32'h0);
    vecs[18] = mkv(0, 4'h0, 32'h0,        4'h0, 4'h0, 32'h0,        32'h0,        1, 32'h1111_1111, 0, 1, 4'h0, 4'h0, 0, 32'h0,        32'h0);
    vecs[19] = mkv(0, 4'h0, 32'h0,        4'h0, 4'h0, 32'h0,        32'h0,        0, 32'h0,        0, 0, 4'h0, 4'h0, 0, 32'h0,        32'h0);
    vecs[20] = mkv(0, 4'h0, 32'h0,        4'h0, 4'h0, 32'h0,        32'h0,        1, 32'h2222_2222, 1, 0, 4'hF, 4'h0, 1, 32'h6000_0004, 32'h0);
    vecs[21] = mkv(0, 4'h0, 32'h0,        4'h0, 4'h0, 32'h0,        32'h0,        0, 32'h0,        0, 0, 4'h0, 4'h0, 0, 32'h0,        32'h0);

    rst_n = 1'b0;
    idle_inputs();
    repeat (2) @(negedge clk);
    #1 chk_all_zero("reset");

    for (int i = 0; i < 22; i++) begin
      string t;
      @(negedge clk);
      t = $sformatf("v%0d", i);
      rst_n = !vecs[i].rst;
      imem_rmask = vecs[i].irm; imem_addr = vecs[i].ia;
      dmem_rmask = vecs[i].drm; dmem_wmask = vecs[i].dwm;
      dmem_addr = vecs[i].da; dmem_wdata = vecs[i].dwd;
      mem_resp = vecs[i].mr; mem_rdata = vecs[i].mrd;
      #1;
      chk({t, "_imem_resp"}, {31'd0, imem_resp}, {31'd0, vecs[i].ei});
      chk({t, "_dmem_resp"}, {31'd0, dmem_resp}, {31'd0, vecs[i].ed});
      chk({t, "_mem_rmask"}, {28'd0, mem_rmask}, {28'd0, vecs[i].emr});
      chk({t, "_mem_wmask"}, {28'd0, mem_wmask}, {28'd0, vecs[i].emw});
      if (vecs[i].aw) begin
        chk({t, "_mem_addr"}, mem_addr, vecs[i].ea);
        chk({t, "_mem_wdata"}, mem_wdata, vecs[i].ewd);
      end
      if (vecs[i].ei) chk({t, "_imem_rdata"}, imem_rdata, vecs[i].mrd);
      if (vecs[i].ed) chk({t, "_dmem_rdata"}, dmem_rdata, vecs[i].mrd);
    end

    // Round robin: both request at once, each re-requests in its own resp cycle.
    begin
      logic order[4];
      logic who = 1'b0;
      logic resp_due = 1'b0;
      int   issued = 0;
      int   nresp = 0;
      for (int cyc = 0; cyc < 60 && nresp < 4; cyc++) begin
        @(negedge clk);
        idle_inputs();
        if (cyc == 0) begin
          imem_rmask = 4'hF; imem_addr = 32'h6000_0100;
          dmem_rmask = 4'hF; dmem_addr = 32'h7000_0100;
        end
        if (resp_due) begin mem_resp = 1'b1; mem_rdata = 32'hA000_0000 + cyc; end
        #1;
        if (resp_due) begin
          resp_due = 1'b0;
          nresp++;
          chk($sformatf("rr_resp%0d", nresp), {30'd0, imem_resp, dmem_resp},
              who ? 32'd1 : 32'd2);
          if (imem_resp && issued < 3) begin imem_rmask = 4'hF; imem_addr = 32'h6000_0100; end
          if (dmem_resp && issued < 3) begin dmem_rmask = 4'hF; dmem_addr = 32'h7000_0100; end
        end
        if (|mem_rmask) begin
          who = (mem_addr[31:28] == 4'h7);
          if (issued < 4) order[issued] = who;
          issued++;
          resp_due = 1'b1;
        end
      end
      chk("rr_done", nresp, 32'd4);
      chk("rr_issue_count", issued, 32'd4);
      for (int k = 0; k < 4; k++)
        chk($sformatf("rr_order%0d_is_dmem", k), {31'd0, order[k]}, (k % 2 == 0) ? 32'd1 : 32'd0);
    end

    // Reset while waiting on memory, then a late response.
    @(negedge clk); idle_inputs(); imem_rmask = 4'hF; imem_addr = 32'h6000_0200;
    @(negedge clk); idle_inputs();
    @(negedge clk); #1 chk("mid_issue_rmask", {28'd0, mem_rmask}, 32'hF);
    @(negedge clk); rst_n = 1'b0;
    #1 chk_all_zero("mid_reset");
    @(negedge clk); rst_n = 1'b1; mem_resp = 1'b1; mem_rdata = 32'hBAD0_BAD0;
    #1;
    chk("late_imem_resp", {31'd0, imem_resp}, 32'd0);
    chk("late_dmem_resp", {31'd0, dmem_resp}, 32'd0);
    @(negedge clk); mem_resp = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      #1 chk($sformatf("post_reset_idle%0d", k), {24'd0, mem_rmask, mem_wmask}, 32'd0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
